// File: rtl/psa_accum.sv
// -----------------------------------------------------------------------------
// psa_accum
//
// Accumulates a stream of packed 4 x 4-bit signed sums from the partitioned
// sub-word adder. Each nibble lane is accumulated independently over a burst.
// The block then presents one packed result per burst. Valid/ready handshakes
// are used on both sides, and only one result is buffered at a time.
//
// Configuration macro:
//   PSA_ACC_SAT_EN  defined   : an overflowing lane clamps to 0x7 / 0x8
//                   undefined : an overflowing lane wraps modulo 16
//   The per-lane overflow flag is set in both builds.
//
// Parameters:
//   BURST_MAX  maximum beats per burst, 1 .. 2**CNT_W-1
//   CNT_W      width of the beat counter and out_count
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       beat present on in_sum / in_err / in_last
//   in_ready       block accepts a beat this cycle (IDLE / ACCUM)
//   in_sum[15:0]   packed lanes [15:12],[11:8],[7:4],[3:0], signed 4-bit
//   in_err         upstream adder overflow flag for this beat
//   in_last        final beat of the burst
//   out_valid      result held and valid (HOLD)
//   out_ready      consumer takes the result
//   out_acc[15:0]  packed lane accumulations
//   out_lane_ovfl  sticky per-lane overflow, bit i = lane [4i+3:4i]
//   out_err        sticky OR of in_err, plus the forced-termination flag
//   out_count      number of beats accepted in the burst
// -----------------------------------------------------------------------------
module psa_accum #(
    parameter int BURST_MAX = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_sum,
    input  logic             in_err,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_acc,
    output logic [3:0]       out_lane_ovfl,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] acc;
        logic [3:0]  ovfl;
    } lane_sum_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    state_t           state;
    lane_sum_t        lane_sum;
    logic             accept;
    logic [CNT_W-1:0] count_next;
    logic             burst_end;

    // Adds the two operands lane by lane in signed 4-bit arithmetic.
    // Overflow occurs when both operands have the same sign but the 4-bit
    // result has the opposite sign.
    function automatic lane_sum_t lane_add(input logic [15:0] a,
                                           input logic [15:0] b);
        lane_sum_t  r;
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] s;
        logic       ov;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x  = a[4*i +: 4];
            y  = b[4*i +: 4];
            s  = {x[3], x} + {y[3], y};
            ov = (x[3] == y[3]) && (s[3] != x[3]);
            r.ovfl[i] = ov;
`ifdef PSA_ACC_SAT_EN
            // The sign of either operand gives the saturation direction.
            r.acc[4*i +: 4] = ov ? (x[3] ? 4'h8 : 4'h7) : s[3:0];
`else
            r.acc[4*i +: 4] = s[3:0];
`endif
        end
        return r;
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        lane_sum   = '0;
        lane_sum   = lane_add(out_acc, in_sum);
        accept     = in_valid && in_ready;
        count_next = out_count + CNT_ONE;
        burst_end  = in_last || (count_next == BURST_LIM);
    end

    // The outputs are the accumulator registers themselves. in_ready and
    // out_valid are registered copies of the state decode, updated together
    // with the state.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_acc       <= '0;
            out_lane_ovfl <= '0;
            out_err       <= 1'b0;
            out_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // The first beat loads the accumulator; no add.
                        out_acc       <= in_sum;
                        out_count     <= CNT_ONE;
                        out_lane_ovfl <= '0;
                        out_err       <= in_err;
                        if (in_last || (BURST_LIM == CNT_ONE)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_err   <= in_err || !in_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        out_acc       <= lane_sum.acc;
                        out_lane_ovfl <= out_lane_ovfl | lane_sum.ovfl;
                        out_count     <= count_next;
                        out_err       <= out_err || in_err;
                        if (burst_end) begin
                            // Reaching BURST_MAX without in_last is a forced
                            // termination, which is reported through out_err.
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_err   <= out_err || in_err || !in_last;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state         <= IDLE;
                        in_ready      <= 1'b1;
                        out_valid     <= 1'b0;
                        out_acc       <= '0;
                        out_lane_ovfl <= '0;
                        out_err       <= 1'b0;
                        out_count     <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/psa_accum.md
# psa_accum

Downstream stage of the 16-bit partitioned sub-word adder: consumes its packed 4×4-bit sum stream plus error flag, accumulates each nibble lane over a burst with signed saturation, and presents one packed result per burst. Used by the PADDSB reduction path, so a multi-operand packed sum is produced without re-issuing through the ALU. Valid/ready on both sides; one result buffered at a time.

## Interface
- BURST_MAX, 15: maximum beats per burst, 1..(2^CNT_W − 1).
- CNT_W, 4: width of the beat counter and out_count.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_sum/in_err/in_last valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_sum  input  16  packed sum; lanes [15:12],[11:8],[7:4],[3:0], each two's-complement 4-bit.
- in_err  input  1  upstream adder overflow flag for this beat.
- in_last  input  1  final beat of burst.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes result.
- out_acc  output  16  packed lane accumulations.
- out_lane_ovfl  output  4  sticky per-lane overflow during accumulation, bit i = lane [4i+3:4i].
- out_err  output  1  sticky OR of any in_err in burst, plus forced-termination flag.
- out_count  output  CNT_W  beats accepted in burst.

## Operation
- States: IDLE, ACCUM, HOLD. Reset → IDLE.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. Beat accepted when in_valid & in_ready.
- IDLE, accept: acc ← in_sum (no add), count ← 1, err ← in_err, ovfl ← 0. in_last → HOLD, else → ACCUM.
- ACCUM, accept: per lane acc_i ← acc_i + in_sum_i (signed 4-bit, range −8..7); count ← count+1; err |= in_err; ovfl_i |= lane overflow (operand signs equal, true-sum sign differs).
- ACCUM → HOLD when accepted beat has in_last=1, or count reaches BURST_MAX with that beat (forced end; sets err=1 unless in_last also 1).
- HOLD: out_valid=1, outputs stable. out_valid & out_ready → IDLE, all accumulators cleared.
- No accept in HOLD; upstream stalls. No bypass of result into next burst.
- in_valid low: state unchanged; no bubble penalty.

## Timing
- Reset values: out_valid 0, out_acc 0x0000, out_lane_ovfl 0, out_err 0, out_count 0; in_ready 1 (IDLE) from the cycle after rst deasserts. Inputs ignored while rst=1.
- Latency: last beat accepted in cycle N → out_valid=1 in N+1.
- Throughput: burst of K beats occupies K accept cycles + ≥1 HOLD cycle; next burst's first beat accepted earliest the cycle after the out handshake.
- out_ready asserted before out_valid has no effect.
- Reset mid-burst or in HOLD: partial result discarded, next cycle as reset values; no output for that burst.
- Single-beat burst (in_last on first beat): out_acc = in_sum, out_count 1, ovfl 0.

## Configuration
- PSA_ACC_SAT_EN defined: overflowing lane clamps to 0x7 (positive) or 0x8 (negative); ovfl_i still set.
- Undefined: lanes wrap modulo 16; ovfl_i still set. All other behaviour identical.

## Test plan
- Reset then 3-beat burst 0x1111, 0x2222, 0x1111 (last on 3rd), out_ready=1 → out_valid next cycle, out_acc 0x4444, count 3, ovfl 0, err 0.
- Burst 0x7070, 0x1010 (last) → with PSA_ACC_SAT_EN: out_acc 0x7070, out_lane_ovfl 4'b1010; without: 0x8080, same ovfl.
- Burst 0x0008, 0x000F (last) → lane0 −8+−1: sat 0x0007? no: result 0x0008 clamped, ovfl 4'b0001; without macro 0x0007.
- 16 beats of 0x0000, no in_last, BURST_MAX=15 → HOLD after 15th, out_count 15, out_err 1; 16th beat stalled (in_ready 0) until out_ready, then starts new burst.
- in_err=1 on middle beat of 3 → out_err 1, out_acc unaffected; out_ready held low 5 cycles → out_valid/outputs stable, in_ready 0 throughout.
- rst pulsed in ACCUM after 2 beats → next cycle out_valid 0, in_ready 1; following burst 0x0101 (last) yields out_acc 0x0101, count 1.
